// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX/MEM input bundle plus branch and write-back outputs of the memory stage
interface mem_stage_if;
  logic        in_valid;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic [4:0]  dest_reg;
  logic        branch;
  logic        zero;
  logic [31:0] branch_target;
  logic        stall_out;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        misalign_err;

  modport master (
    output in_valid, alu_result, store_data, mem_read, mem_write, reg_write,
           mem_to_reg, dest_reg, branch, zero, branch_target,
    input  stall_out, pc_src, pc_target, wb_valid, wb_reg_write, wb_dest,
           wb_data, misalign_err
  );

  modport slave (
    input  in_valid, alu_result, store_data, mem_read, mem_write, reg_write,
           mem_to_reg, dest_reg, branch, zero, branch_target,
    output stall_out, pc_src, pc_target, wb_valid, wb_reg_write, wb_dest,
           wb_data, misalign_err
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: word load/store with fixed latency, branch resolve, write-back register
module mem_stage #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  ex
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [31:0] alu_q, sd_q;
  logic        rd_q, wr_q, rw_q, m2r_q;
  logic [4:0]  dest_q;

  logic        pc_src_q;
  logic [31:0] pc_target_q;
  logic        wb_valid_q, wb_rw_q, misalign_q;
  logic [4:0]  wb_dest_q;
  logic [31:0] wb_data_q;

  // Contents survive reset; only the power-up value is defined.
  logic [31:0] mem_q [1 << ADDR_W] = '{default: '0};

  logic              busy, accept, in_mem;
  logic [31:0]       s_alu, s_sd;
  logic              s_rd, s_wr, s_rw, s_m2r;
  logic [4:0]        s_dest;
  logic [ADDR_W-1:0] s_addr;
  logic              s_mem, s_mis;
  logic              done, mem_we, wb_rw_d;
  logic [31:0]       wb_data_d;

  assign busy   = (state_q == BUSY);
  assign accept = !busy && ex.in_valid;
  assign in_mem = ex.mem_read || ex.mem_write;

  // Completion operands: live inputs when finishing at the accept edge, latched copy when finishing from BUSY.
  always_comb begin
    s_alu  = busy ? alu_q  : ex.alu_result;
    s_sd   = busy ? sd_q   : ex.store_data;
    s_rd   = busy ? rd_q   : ex.mem_read;
    s_wr   = busy ? wr_q   : ex.mem_write;
    s_rw   = busy ? rw_q   : ex.reg_write;
    s_m2r  = busy ? m2r_q  : ex.mem_to_reg;
    s_dest = busy ? dest_q : ex.dest_reg;
    s_addr = s_alu[ADDR_W+1:2];
    s_mem  = s_rd || s_wr;
    s_mis  = s_mem && (s_alu[1:0] != 2'b00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && in_mem && (LATENCY > 1)) begin
          state_d = BUSY;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // A write with both mem_read and mem_write set is a store; misaligned ops never touch memory.
  always_comb begin
    done      = (accept && (!in_mem || (LATENCY == 1))) || (busy && (cnt_q == 4'd1));
    mem_we    = done && s_wr && !s_mis;
    wb_rw_d   = s_rw && !s_wr && !s_mis;
    wb_data_d = s_alu;
    if (s_mis)
      wb_data_d = 32'h0;
    else if (s_rd && !s_wr && s_m2r)
      wb_data_d = mem_q[s_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_q  <= 32'h0;
      sd_q   <= 32'h0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      rw_q   <= 1'b0;
      m2r_q  <= 1'b0;
      dest_q <= 5'd0;
    end else if (accept) begin
      alu_q  <= ex.alu_result;
      sd_q   <= ex.store_data;
      rd_q   <= ex.mem_read;
      wr_q   <= ex.mem_write;
      rw_q   <= ex.reg_write;
      m2r_q  <= ex.mem_to_reg;
      dest_q <= ex.dest_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_src_q    <= 1'b0;
      pc_target_q <= 32'h0;
      wb_valid_q  <= 1'b0;
      wb_rw_q     <= 1'b0;
      wb_dest_q   <= 5'd0;
      wb_data_q   <= 32'h0;
      misalign_q  <= 1'b0;
    end else begin
      pc_src_q   <= accept && ex.branch && ex.zero;
      if (accept) pc_target_q <= ex.branch_target;
      wb_valid_q <= done;
      wb_rw_q    <= done && wb_rw_d;
      if (done) begin
        wb_dest_q <= s_dest;
        wb_data_q <= wb_data_d;
      end
      if (done && s_mis) misalign_q <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (mem_we) mem_q[s_addr] <= s_sd;
  end

  assign ex.stall_out    = busy;
  assign ex.pc_src       = pc_src_q;
  assign ex.pc_target    = pc_target_q;
  assign ex.wb_valid     = wb_valid_q;
  assign ex.wb_reg_write = wb_rw_q;
  assign ex.wb_dest      = wb_dest_q;
  assign ex.wb_data      = wb_data_q;
  assign ex.misalign_err = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed bench for mem_stage at LATENCY 2 and LATENCY 4
module tb_mem_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset2, reset4;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_stage_if ifc2();
  mem_stage_if ifc4();

  mem_stage #(.ADDR_W(8), .LATENCY(2)) dut2 (.clk(clk), .reset(reset2), .ex(ifc2));
  mem_stage #(.ADDR_W(8), .LATENCY(4)) dut4 (.clk(clk), .reset(reset4), .ex(ifc4));

  assign ifc4.in_valid      = ifc2.in_valid;
  assign ifc4.alu_result    = ifc2.alu_result;
  assign ifc4.store_data    = ifc2.store_data;
  assign ifc4.mem_read      = ifc2.mem_read;
  assign ifc4.mem_write     = ifc2.mem_write;
  assign ifc4.reg_write     = ifc2.reg_write;
  assign ifc4.mem_to_reg    = ifc2.mem_to_reg;
  assign ifc4.dest_reg      = ifc2.dest_reg;
  assign ifc4.branch        = ifc2.branch;
  assign ifc4.zero          = ifc2.zero;
  assign ifc4.branch_target = ifc2.branch_target;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic rd, input logic wr, input logic rw, input logic m2r,
                       input logic [4:0] dest, input logic br, input logic z,
                       input logic [31:0] tgt);
    ifc2.in_valid      = v;
    ifc2.alu_result    = alu;
    ifc2.store_data    = sd;
    ifc2.mem_read      = rd;
    ifc2.mem_write     = wr;
    ifc2.reg_write     = rw;
    ifc2.mem_to_reg    = m2r;
    ifc2.dest_reg      = dest;
    ifc2.branch        = br;
    ifc2.zero          = z;
    ifc2.branch_target = tgt;
  endtask

  task automatic idle;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset2 = 1'b1;
    reset4 = 1'b1;
    idle();
    tick();
    tick();
    check("rst_stall",    ifc2.stall_out,    0);
    check("rst_wb_valid", ifc2.wb_valid,     0);
    check("rst_wb_rw",    ifc2.wb_reg_write, 0);
    check("rst_wb_dest",  ifc2.wb_dest,      0);
    check("rst_wb_data",  ifc2.wb_data,      0);
    check("rst_pc_src",   ifc2.pc_src,       0);
    check("rst_pc_tgt",   ifc2.pc_target,    0);
    check("rst_misalign", ifc2.misalign_err, 0);
    reset2 = 1'b0;

    // non-memory op completes one cycle after accept
    drive(1'b1, 32'h7, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 32'h0);
    tick();
    check("alu_stall",    ifc2.stall_out,    0);
    check("alu_wb_valid", ifc2.wb_valid,     1);
    check("alu_wb_dest",  ifc2.wb_dest,      5);
    check("alu_wb_data",  ifc2.wb_data,      32'h7);
    check("alu_wb_rw",    ifc2.wb_reg_write, 1);
    idle();
    tick();
    check("gap_wb_valid", ifc2.wb_valid,     0);
    check("gap_wb_rw",    ifc2.wb_reg_write, 0);
    check("gap_wb_hold",  ifc2.wb_data,      32'h7);

    // store 0xDEADBEEF to 0x10
    drive(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 32'h0);
    tick();
    check("st_stall",     ifc2.stall_out,    1);
    check("st_busy_wbv",  ifc2.wb_valid,     0);
    idle();
    tick();
    check("st_done_stall", ifc2.stall_out,   0);
    check("st_wb_valid",  ifc2.wb_valid,     1);
    check("st_wb_rw",     ifc2.wb_reg_write, 0);

    // load from 0x10; inputs changed while busy must be ignored, then accepted after completion
    drive(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 32'h0);
    tick();
    check("ld_stall",     ifc2.stall_out,    1);
    drive(1'b1, 32'h99, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 32'h0);
    tick();
    check("ld_wb_valid",  ifc2.wb_valid,     1);
    check("ld_wb_data",   ifc2.wb_data,      32'hDEADBEEF);
    check("ld_wb_dest",   ifc2.wb_dest,      9);
    check("ld_wb_rw",     ifc2.wb_reg_write, 1);
    check("ld_done_stall", ifc2.stall_out,   0);
    tick();
    check("b2b_wb_valid", ifc2.wb_valid,     1);
    check("b2b_wb_data",  ifc2.wb_data,      32'h99);
    check("b2b_wb_dest",  ifc2.wb_dest,      7);
    idle();
    tick();

    // taken and not-taken branch
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 32'h40);
    tick();
    check("br_pc_src",    ifc2.pc_src,       1);
    check("br_pc_tgt",    ifc2.pc_target,    32'h40);
    check("br_wb_rw",     ifc2.wb_reg_write, 0);
    idle();
    tick();
    check("br_pulse_end", ifc2.pc_src,       0);
    check("br_tgt_hold",  ifc2.pc_target,    32'h40);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h80);
    tick();
    check("nt_pc_src",    ifc2.pc_src,       0);
    idle();
    tick();
    check("nt_pc_src2",   ifc2.pc_src,       0);

    // misaligned store to 0x13 must not modify word 4
    drive(1'b1, 32'h13, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 32'h0);
    tick();
    check("mis_stall",    ifc2.stall_out,    1);
    idle();
    tick();
    check("mis_wb_valid", ifc2.wb_valid,     1);
    check("mis_wb_rw",    ifc2.wb_reg_write, 0);
    check("mis_wb_data",  ifc2.wb_data,      0);
    check("mis_flag",     ifc2.misalign_err, 1);
    drive(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    check("mis_ld_data",  ifc2.wb_data,      32'hDEADBEEF);
    check("mis_sticky",   ifc2.misalign_err, 1);

    // misaligned load suppresses register write
    drive(1'b1, 32'h11, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    check("misld_wbv",    ifc2.wb_valid,     1);
    check("misld_rw",     ifc2.wb_reg_write, 0);
    check("misld_data",   ifc2.wb_data,      0);

    // address wrap: 0x400 aliases 0x000
    drive(1'b1, 32'h400, 32'h5555AAAA, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    drive(1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    check("wrap_data",    ifc2.wb_data,      32'h5555AAAA);
    check("wrap_dest",    ifc2.wb_dest,      8);

    // LATENCY=4: reset in the second BUSY cycle of a store of 0x1234 to 0x20
    reset4 = 1'b0;
    check("l4_rst_stall", ifc4.stall_out,    0);
    drive(1'b1, 32'h20, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 32'h0);
    tick();
    check("l4_busy1",     ifc4.stall_out,    1);
    idle();
    tick();
    check("l4_busy2",     ifc4.stall_out,    1);
    reset4 = 1'b1;
    #1;
    check("l4_async_stall", ifc4.stall_out,  0);
    check("l4_async_wbv", ifc4.wb_valid,     0);
    check("l4_async_data", ifc4.wb_data,     0);
    tick();
    reset4 = 1'b0;
    tick();
    check("l4_no_pulse",  ifc4.wb_valid,     0);
    drive(1'b1, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    check("l4_ld_stall",  ifc4.stall_out,    1);
    tick();
    tick();
    check("l4_ld_wait",   ifc4.wb_valid,     0);
    check("l4_ld_stall3", ifc4.stall_out,    1);
    tick();
    check("l4_ld_wbv",    ifc4.wb_valid,     1);
    check("l4_ld_data",   ifc4.wb_data,      0);
    check("l4_ld_dest",   ifc4.wb_dest,      10);
    check("l4_ld_stall0", ifc4.stall_out,    0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
